// File: rtl/fmc_i2c_init_seq_pkg.sv
// Shared types and constants for the FMC424 I2C init sequencer: table entry layout,
// opcodes, FSM states and well-known device addresses.
package fmc_i2c_pkg;

  typedef enum logic [1:0] {
    OP_WRITE      = 2'b00,
    OP_READ_CHECK = 2'b01,
    OP_DELAY      = 2'b10,
    OP_END        = 2'b11
  } op_e;

  // 33-bit table word; field order matches the external ROM layout.
  typedef struct packed {
    op_e        op;
    logic [6:0] dev;
    logic [7:0] reg_addr;
    logic [7:0] data;
    logic [7:0] mask;
  } seq_entry_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_WAIT_DLY,
    ST_NEXT,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam logic [6:0] DEV_CPLD    = 7'b0111110;
  localparam logic [6:0] DEV_SI5338B = 7'b1110000;
  localparam logic [6:0] DEV_QSFP    = 7'b1010000;

  // A 16-bit delay field times the default scale needs the full 26 bits.
  localparam int DLY_W = 26;

  function automatic logic rd_match(input logic [7:0] rdata,
                                    input logic [7:0] expected,
                                    input logic [7:0] mask);
    return ((rdata & mask) == (expected & mask));
  endfunction

endpackage

// File: rtl/fmc_i2c_init_seq_if.sv
// Command/response channel between the init sequencer (master) and the
// FMC424 I2C master controller (slave).
interface fmc_i2c_init_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_dev;
  logic [7:0] cmd_reg;
  logic [7:0] cmd_wdata;
  logic       cmd_rw;
  logic       rsp_valid;
  logic       rsp_nack;
  logic [7:0] rsp_rdata;

  modport master (
    output cmd_valid, cmd_dev, cmd_reg, cmd_wdata, cmd_rw,
    input  cmd_ready, rsp_valid, rsp_nack, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_dev, cmd_reg, cmd_wdata, cmd_rw,
    output cmd_ready, rsp_valid, rsp_nack, rsp_rdata
  );
endinterface

// File: rtl/fmc_i2c_init_seq_delay_cnt.sv
// Loadable down-counter for DELAY entries; saturates at zero and flags it.
module seq_delay_cnt
  import fmc_i2c_pkg::*;
#(
  parameter int W = DLY_W
) (
  input  logic         CLK,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/fmc_i2c_init_seq.sv
// Power-up I2C init sequencer: walks an external config table and issues one
// controller transaction per entry. Optional NACK retry: FMC_I2C_SEQ_RETRY_EN.
module fmc_i2c_init_seq
  import fmc_i2c_pkg::*;
#(
  parameter int NUM_ENTRIES = 64,
  parameter int DELAY_SCALE = 1000,
  parameter int MAX_RETRIES = 3,
  localparam int IDX_W = $clog2(NUM_ENTRIES)
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [IDX_W-1:0]     tbl_addr,
  input  logic [32:0]          tbl_data,
  fmc_i2c_init_seq_if.master   bus,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [IDX_W-1:0]     err_idx
);

  seq_entry_t ent;
  assign ent = seq_entry_t'(tbl_data);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  op_e              op_q, op_d;
  logic [7:0]       mask_q, mask_d;
  logic [6:0]       dev_q, dev_d;
  logic [7:0]       reg_q, reg_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             rw_q, rw_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [IDX_W-1:0] err_idx_q, err_idx_d;

  logic             retry_ok;
  logic             dly_load, dly_dec, dly_zero;
  logic [DLY_W-1:0] dly_total, dly_load_val;
  logic             rsp_fail;

  // The delay field is 16 bits wide; counting total-1 gives exactly max(total,1)
  // cycles in WAIT_DLY, so a zero delay still spends one cycle there.
  assign dly_total    = DLY_W'({ent.reg_addr, ent.data}) * DLY_W'(DELAY_SCALE);
  assign dly_load_val = (dly_total == '0) ? '0 : dly_total - DLY_W'(1);

  assign rsp_fail = (op_q == OP_READ_CHECK) && !rd_match(bus.rsp_rdata, wdata_q, mask_q);

  // State register
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (start) state_d = ST_FETCH;
      ST_FETCH:    state_d = ST_DECODE;
      ST_DECODE: begin
        case (ent.op)
          OP_WRITE, OP_READ_CHECK: state_d = ST_ISSUE;
          OP_DELAY:                state_d = ST_WAIT_DLY;
          default:                 state_d = ST_DONE;
        endcase
      end
      ST_ISSUE:    if (bus.cmd_ready) state_d = ST_WAIT_RSP;
      ST_WAIT_RSP: begin
        if (bus.rsp_valid) begin
          if (bus.rsp_nack) begin
            state_d = retry_ok ? ST_ISSUE : ST_ERROR;
          end else if (rsp_fail) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_NEXT;
          end
        end
      end
      ST_WAIT_DLY: if (dly_zero) state_d = ST_NEXT;
      ST_NEXT:     state_d = (idx_q == IDX_W'(NUM_ENTRIES - 1)) ? ST_DONE : ST_FETCH;
      ST_DONE:     state_d = ST_IDLE;
      ST_ERROR:    state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; cmd_valid therefore drops with the async reset.
  always_comb begin
    bus.cmd_valid = (state_q == ST_ISSUE);
    busy          = (state_q != ST_IDLE);
    dly_load      = (state_q == ST_DECODE) && (ent.op == OP_DELAY);
    dly_dec       = (state_q == ST_WAIT_DLY);
  end

  always_comb begin
    idx_d     = idx_q;
    op_d      = op_q;
    mask_d    = mask_q;
    dev_d     = dev_q;
    reg_d     = reg_q;
    wdata_d   = wdata_q;
    rw_d      = rw_q;
    done_d    = done_q;
    error_d   = error_q;
    err_idx_d = err_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d     = '0;
          done_d    = 1'b0;
          error_d   = 1'b0;
          err_idx_d = '0;
        end
      end
      ST_DECODE: begin
        op_d = ent.op;
        // Bus fields only move for bus entries so they stay stable across delays.
        if (ent.op == OP_WRITE || ent.op == OP_READ_CHECK) begin
          dev_d   = ent.dev;
          reg_d   = ent.reg_addr;
          wdata_d = ent.data;
          mask_d  = ent.mask;
          rw_d    = (ent.op == OP_READ_CHECK);
        end
      end
      ST_NEXT:  idx_d = idx_q + IDX_W'(1);
      ST_DONE:  done_d = 1'b1;
      ST_ERROR: begin
        error_d   = 1'b1;
        err_idx_d = idx_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      op_q      <= OP_WRITE;
      mask_q    <= '0;
      dev_q     <= '0;
      reg_q     <= '0;
      wdata_q   <= '0;
      rw_q      <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      err_idx_q <= '0;
    end else begin
      idx_q     <= idx_d;
      op_q      <= op_d;
      mask_q    <= mask_d;
      dev_q     <= dev_d;
      reg_q     <= reg_d;
      wdata_q   <= wdata_d;
      rw_q      <= rw_d;
      done_q    <= done_d;
      error_q   <= error_d;
      err_idx_q <= err_idx_d;
    end
  end

`ifdef FMC_I2C_SEQ_RETRY_EN
  localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  logic [RETRY_W-1:0] retry_q, retry_d;

  assign retry_ok = (int'(retry_q) < MAX_RETRIES);

  always_comb begin
    retry_d = retry_q;
    if ((state_q == ST_IDLE && start) || state_d == ST_NEXT) begin
      retry_d = '0;
    end else if (state_q == ST_WAIT_RSP && bus.rsp_valid && bus.rsp_nack && retry_ok) begin
      retry_d = retry_q + RETRY_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      retry_q <= '0;
    end else begin
      retry_q <= retry_d;
    end
  end
`else
  assign retry_ok = 1'b0;
`endif

  seq_delay_cnt #(.W(DLY_W)) u_delay_cnt (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .load     (dly_load),
    .load_val (dly_load_val),
    .dec      (dly_dec),
    .zero     (dly_zero)
  );

  assign tbl_addr      = idx_q;
  assign bus.cmd_dev   = dev_q;
  assign bus.cmd_reg   = reg_q;
  assign bus.cmd_wdata = wdata_q;
  assign bus.cmd_rw    = rw_q;
  assign done          = done_q;
  assign error         = error_q;
  assign err_idx       = err_idx_q;

endmodule

// File: tb/tb_fmc_i2c_init_seq.sv
// Directed bench for fmc_i2c_init_seq: table ROM model plus an inline
// controller responder driven from the single stimulus initial block.
module tb_fmc_i2c_init_seq;
  import fmc_i2c_pkg::*;

  localparam int N = 8;
  localparam logic [32:0] END_W = {2'b11, 31'd0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  tbl_addr;
  logic [32:0] tbl_data;
  logic        busy, done, error;
  logic [2:0]  err_idx;
  logic [32:0] tbl [0:N-1];

  fmc_i2c_init_seq_if bus ();

  fmc_i2c_init_seq #(
    .NUM_ENTRIES (N),
    .DELAY_SCALE (4),
    .MAX_RETRIES (3)
  ) dut (
    .CLK      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .tbl_addr (tbl_addr),
    .tbl_data (tbl_data),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .err_idx  (err_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tbl_data <= tbl[tbl_addr];

  int total = 0;
  int bad = 0;
  int issues, held, stable_bad, done_k, first_k;
  logic [6:0] f_dev;
  logic [7:0] f_reg, f_wd;
  logic       f_rw;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] ent(input logic [1:0] op, input logic [6:0] dev,
                                      input logic [7:0] r, input logic [7:0] d,
                                      input logic [7:0] m);
    return {op, dev, r, d, m};
  endfunction

  task automatic clear_tbl();
    for (int i = 0; i < N; i++) tbl[i] = END_W;
  endtask

  // Pulse start, then act as the I2C controller until done/error, abort_k, or budget.
  // hold: cycles cmd_ready stays low once cmd_valid is seen (0 = ready tied high).
  task automatic run_seq(input int hold, input int restart_k, input int abort_k,
                         input logic [7:0] nack_reg, input int nacks, input logic [7:0] rd);
    int pend, vcount, nack_left;
    logic [7:0] cur_reg;
    logic [23:0] snap;
    pend = 0; vcount = 0; nack_left = nacks; cur_reg = 8'h00; snap = '0;
    issues = 0; held = 0; stable_bad = 0; done_k = -1; first_k = -1;
    @(negedge clk);
    start = 1'b1;
    bus.cmd_ready = (hold == 0);
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      start = (k == restart_k);
      bus.rsp_valid = 1'b0; bus.rsp_nack = 1'b0; bus.rsp_rdata = 8'h00;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.rsp_valid = 1'b1;
          bus.rsp_rdata = rd;
          if (cur_reg == nack_reg && nack_left > 0) begin
            bus.rsp_nack = 1'b1;
            nack_left--;
          end
        end
      end
      if (done === 1'b1 || error === 1'b1) begin
        done_k = k;
        break;
      end
      if (k == abort_k) break;
      if (bus.cmd_valid === 1'b1) begin
        if (first_k < 0) first_k = k;
        if (vcount == 0) snap = {1'b0, bus.cmd_dev, bus.cmd_reg, bus.cmd_wdata} ^ {23'd0, bus.cmd_rw};
        else if (snap != ({1'b0, bus.cmd_dev, bus.cmd_reg, bus.cmd_wdata} ^ {23'd0, bus.cmd_rw})) stable_bad++;
        bus.cmd_ready = (vcount >= hold);
        vcount++;
        if (bus.cmd_ready) begin
          issues++;
          held = vcount;
          cur_reg = bus.cmd_reg;
          if (issues == 1) begin
            f_dev = bus.cmd_dev; f_reg = bus.cmd_reg; f_wd = bus.cmd_wdata; f_rw = bus.cmd_rw;
          end
          pend = 2;
          vcount = 0;
        end
      end else begin
        if (vcount > 0) stable_bad++;
        bus.cmd_ready = (hold == 0);
      end
    end
    start = 1'b0;
    bus.rsp_valid = 1'b0; bus.rsp_nack = 1'b0; bus.cmd_ready = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0;
    bus.cmd_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_nack = 1'b0; bus.rsp_rdata = 8'h00;
    clear_tbl();
    repeat (3) @(negedge clk);
    // Reset state
    chk("rst_cmd_valid", {31'd0, bus.cmd_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_error", {31'd0, error}, 0);
    chk("rst_err_idx", {29'd0, err_idx}, 0);
    chk("rst_tbl_addr", {29'd0, tbl_addr}, 0);
    chk("rst_fields", {9'd0, bus.cmd_dev, bus.cmd_reg, bus.cmd_wdata}, 0);
    chk("rst_rw", {31'd0, bus.cmd_rw}, 0);
    rst_n = 1'b1;
    settle();

    // Single WRITE then END
    tbl[0] = ent(2'b00, 7'h70, 8'h10, 8'hA5, 8'h00);
    run_seq(0, -1, -1, 8'hFF, 0, 8'h00);
    chk("w_issues", issues, 1);
    chk("w_first_valid_cycle", first_k, 3);
    chk("w_dev", {25'd0, f_dev}, 32'h70);
    chk("w_reg", {24'd0, f_reg}, 32'h10);
    chk("w_wdata", {24'd0, f_wd}, 32'hA5);
    chk("w_rw", {31'd0, f_rw}, 0);
    chk("w_done_cycle", done_k, 10);
    chk("w_done", {31'd0, done}, 1);
    chk("w_error", {31'd0, error}, 0);
    chk("w_valid_cycles", held, 1);
    settle();

    // start pulsed in DONE state is ignored
    run_seq(0, 9, -1, 8'hFF, 0, 8'h00);
    settle();
    chk("start_in_done_busy", {31'd0, busy}, 0);
    chk("start_in_done_issues", issues, 1);

    // start pulsed while busy mid-sequence is ignored
    run_seq(0, 5, -1, 8'hFF, 0, 8'h00);
    chk("start_busy_issues", issues, 1);
    chk("start_busy_done_cycle", done_k, 10);
    settle();

    // READ_CHECK pass and fail
    clear_tbl();
    tbl[0] = ent(2'b00, 7'h70, 8'h02, 8'h01, 8'h00);
    tbl[1] = ent(2'b01, 7'h3E, 8'h01, 8'h80, 8'h80);
    run_seq(0, -1, -1, 8'hFF, 0, 8'h85);
    chk("rc_pass_done", {31'd0, done}, 1);
    chk("rc_pass_error", {31'd0, error}, 0);
    chk("rc_pass_issues", issues, 2);
    settle();
    run_seq(0, -1, -1, 8'hFF, 0, 8'h05);
    chk("rc_fail_error", {31'd0, error}, 1);
    chk("rc_fail_done", {31'd0, done}, 0);
    chk("rc_fail_err_idx", {29'd0, err_idx}, 1);
    chk("rc_fail_issues", issues, 2);
    settle();

    // cmd_ready held low for 20 cycles
    clear_tbl();
    tbl[0] = ent(2'b00, DEV_CPLD, 8'h05, 8'h11, 8'h00);
    run_seq(20, -1, -1, 8'hFF, 0, 8'h00);
    chk("hold_valid_cycles", held, 21);
    chk("hold_stable", stable_bad, 0);
    chk("hold_issues", issues, 1);
    chk("hold_dev", {25'd0, f_dev}, {25'd0, DEV_CPLD});
    chk("hold_done", {31'd0, done}, 1);
    settle();

    // NACK on entry 2
    clear_tbl();
    for (int i = 0; i < 4; i++) tbl[i] = ent(2'b00, DEV_QSFP, 8'h20 + 8'(i), 8'h00, 8'h00);
`ifdef FMC_I2C_SEQ_RETRY_EN
    run_seq(0, -1, -1, 8'h22, 100, 8'h00);
    chk("nack_issues", issues, 6);
`else
    run_seq(0, -1, -1, 8'h22, 1, 8'h00);
    chk("nack_issues", issues, 3);
`endif
    chk("nack_error", {31'd0, error}, 1);
    chk("nack_err_idx", {29'd0, err_idx}, 2);
    chk("nack_done", {31'd0, done}, 0);
    settle();
`ifdef FMC_I2C_SEQ_RETRY_EN
    run_seq(0, -1, -1, 8'h22, 1, 8'h00);
    chk("retry_issues", issues, 5);
    chk("retry_done", {31'd0, done}, 1);
    chk("retry_error", {31'd0, error}, 0);
    settle();
`endif

    // DELAY 5 * scale 4 = 20 cycles, and DELAY 0 = 1 cycle
    clear_tbl();
    tbl[0] = ent(2'b10, 7'h00, 8'h00, 8'h05, 8'h00);
    run_seq(0, -1, -1, 8'hFF, 0, 8'h00);
    chk("dly20_done_cycle", done_k, 27);
    chk("dly20_issues", issues, 0);
    settle();
    tbl[0] = ent(2'b10, 7'h00, 8'h00, 8'h00, 8'h00);
    run_seq(0, -1, -1, 8'hFF, 0, 8'h00);
    chk("dly0_done_cycle", done_k, 8);
    settle();

    // No END in a full table: implicit end after the last entry
    for (int i = 0; i < N; i++) tbl[i] = ent(2'b00, DEV_SI5338B, 8'h40 + 8'(i), 8'(i), 8'h00);
    run_seq(0, -1, -1, 8'hFF, 0, 8'h00);
    chk("full_issues", issues, N);
    chk("full_done", {31'd0, done}, 1);
    chk("full_error", {31'd0, error}, 0);
    settle();

    // Async reset in WAIT_RSP
    clear_tbl();
    tbl[0] = ent(2'b00, 7'h70, 8'h10, 8'hA5, 8'h00);
    tbl[1] = ent(2'b00, 7'h70, 8'h11, 8'h5A, 8'h00);
    run_seq(0, -1, 4, 8'hFF, 0, 8'h00);
    chk("pre_rst_busy", {31'd0, busy}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", {31'd0, busy}, 0);
    chk("async_rst_valid", {31'd0, bus.cmd_valid}, 0);
    chk("async_rst_done", {31'd0, done}, 0);
    chk("async_rst_tbl_addr", {29'd0, tbl_addr}, 0);
    @(negedge clk) rst_n = 1'b1;

    // Async reset in ISSUE with cmd_valid high
    run_seq(50, -1, 6, 8'hFF, 0, 8'h00);
    chk("pre_rst_valid", {31'd0, bus.cmd_valid}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_issue_valid", {31'd0, bus.cmd_valid}, 0);
    chk("async_rst_issue_busy", {31'd0, busy}, 0);
    @(negedge clk) rst_n = 1'b1;

    // Restart after reset begins at entry 0
    run_seq(0, -1, -1, 8'hFF, 0, 8'h00);
    chk("restart_first_valid", first_k, 3);
    chk("restart_first_reg", {24'd0, f_reg}, 32'h10);
    chk("restart_issues", issues, 2);
    chk("restart_done", {31'd0, done}, 1);
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fmc_i2c_init_seq.md
# fmc_i2c_init_seq

Command sequencer that sits directly upstream of the FMC424 I2C master controller. It walks an external configuration table entry by entry and issues one register transaction per entry to the controller over a valid/ready command channel. It waits for each transaction's response, checks read results and NACKs, and reports done or error. It brings up the FMC424 CPLD, the SI5338B and the QSFP modules after power-up without software involvement.

## Interface
- `NUM_ENTRIES`, default 64: table depth; index width `IDX_W = $clog2(NUM_ENTRIES)`.
- `DELAY_SCALE`, default 1000: CLK cycles per DELAY unit.
- `MAX_RETRIES`, default 3: NACK retries per entry (used only with the retry macro).
- `CLK` in, 1: system clock.
- `rst_n` in, 1: asynchronous, active-low reset.
- `start` in, 1: single-cycle pulse that begins the sequence at entry 0.
- `tbl_addr` out, IDX_W: table read address.
- `tbl_data` in, 33: entry `{op[1:0], dev[6:0], reg[7:0], data[7:0], mask[7:0]}`, valid one cycle after `tbl_addr`.
- `cmd_valid` out, 1 / `cmd_ready` in, 1: command handshake to the I2C controller.
- `cmd_dev` out, 7; `cmd_reg` out, 8; `cmd_wdata` out, 8; `cmd_rw` out, 1 (0 = write, 1 = read).
- `rsp_valid` in, 1; `rsp_nack` in, 1; `rsp_rdata` in, 8: single-cycle transaction completion from the controller.
- `busy` out, 1; `done` out, 1; `error` out, 1; `err_idx` out, IDX_W.

## Operation
- Opcodes:
  - WRITE (00): write `data` to `dev`/`reg`.
  - READ_CHECK (01): read `dev`/`reg`; pass if `(rdata & mask) == (data & mask)`.
  - DELAY (10): wait `{reg, data} * DELAY_SCALE` cycles; no bus activity.
  - END (11): sequence complete.
- States:
  - IDLE: on `start`, go to FETCH, clear `done`, `error` and `err_idx`, and set index to 0.
  - FETCH: drive `tbl_addr` = index, then go to DECODE.
  - DECODE: latch the entry. WRITE and READ_CHECK go to ISSUE, DELAY goes to WAIT_DLY, END goes to DONE.
  - ISSUE: `cmd_valid` = 1 with fields held stable. On `cmd_valid & cmd_ready`, go to WAIT_RSP.
  - WAIT_RSP: on `rsp_valid`:
    - NACK: go to ERROR (see Configuration).
    - READ_CHECK mismatch: go to ERROR.
    - Otherwise: go to NEXT.
  - WAIT_DLY: count down to 0, then go to NEXT. A count of 0 takes exactly one cycle in WAIT_DLY.
  - NEXT: increment index. If the index was `NUM_ENTRIES-1`, go to DONE (implicit END); otherwise go to FETCH.
  - DONE: `done` = 1 (sticky), then go to IDLE.
  - ERROR: `error` = 1 (sticky), `err_idx` = failing index, then go to IDLE.
- `busy` = 1 in every state except IDLE.
- `start` while `busy` is ignored.
- `rsp_valid` outside WAIT_RSP is ignored.
- `cmd_ready` outside ISSUE is ignored.
- Delay counter is 26 bits; the product is computed at full width with no truncation.

## Timing
- Reset values: `cmd_valid` = 0, `busy` = 0, `done` = 0, `error` = 0, `err_idx` = 0, `tbl_addr` = 0, and all cmd fields = 0. State goes to IDLE.
- Reset mid-sequence: `cmd_valid` drops asynchronously, and no partial state survives.
- Command fields are registered and change only in DECODE.
- Once asserted, `cmd_valid` holds until the handshake completes.
- `start` to first `cmd_valid` is 3 cycles: IDLE → FETCH → DECODE → ISSUE.
- Response to next command is 4 cycles: NEXT → FETCH → DECODE → ISSUE.
- `done` and `error` rise the cycle after entering DONE or ERROR. They are never high together.

## Configuration
- `FMC_I2C_SEQ_RETRY_EN` defined:
  - On NACK with retry count < `MAX_RETRIES`, increment the count and return to ISSUE with the same fields.
  - The count clears on entry to NEXT.
  - READ_CHECK mismatch is not retried.
- `FMC_I2C_SEQ_RETRY_EN` undefined: any NACK goes to ERROR immediately, and no retry counter is synthesized.

## Structure
- Package `fmc_i2c_pkg` holds:
  - the `op_e` enum;
  - the packed `seq_entry_t` struct (33 bits);
  - the state enum;
  - device address constants: CPLD 7'b0111110, SI5338B 7'b1110000, QSFP 7'b1010000.
- The table ROM is outside this block and is reached only through the `tbl_addr`/`tbl_data` ports.
- One sub-module, `seq_delay_cnt`: a loadable down-counter with a zero flag.

## Test plan
- Table {WRITE 0x70/0x10/0xA5, END}, `cmd_ready` tied 1, `rsp` 2 cycles after accept → exactly one command. `cmd_valid` at cycle 3 after `start`, fields 0x70/0x10/0xA5/w. `done` = 1, `error` = 0.
- READ_CHECK data 0x80, mask 0x80:
  - `rdata` 0x85 → pass.
  - `rdata` 0x05 → `error` = 1, `err_idx` = entry index.
- `cmd_ready` held low 20 cycles → `cmd_valid` and fields stable throughout; one transaction after `ready`.
- NACK on entry 2:
  - Without macro: `error` with `err_idx` = 2.
  - With macro and `MAX_RETRIES` = 3: 4 issues of entry 2 then `error`. A single NACK followed by ACK → sequence continues.
- DELAY {0x00, 0x05}, `DELAY_SCALE` = 4 → 20 cycles in WAIT_DLY. Count 0 → 1 cycle.
- `rst_n` low during WAIT_RSP → `cmd_valid`, `busy` and `done` are 0 immediately. A new `start` restarts at entry 0. `start` while `busy` → no effect.
